hazard_scoreboard: RTL and testbench

- Parametrised hazard unit for the in-order MIPS pipeline; generalises the 5-stage forward/lw-stall unit to NSTG post-decode stages (E, M, ..., W) and per-instruction result latency.
- Tracks every in-flight destination in a shift-register scoreboard, one slot per stage from E to W.
- Issues decode stalls, E-stage forwarding selects and E bubbles, and accepts an external flush.
- Keeps a saturating stall counter for performance monitoring.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_scoreboard_sb_match.sv | 32 +++
 rtl/hazard_scoreboard.sv | 111 +++++++++++
 tb/tb_hazard_scoreboard.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard scoreboard: one slot per post-decode stage.
package hazard_pkg;

    localparam int SB_REGW = 8;
    localparam int SB_LATW = 8;
    localparam int FWD_RF  = 0;

    typedef struct packed {
        logic               valid;
        logic [SB_REGW-1:0] dst;
        logic [SB_LATW-1:0] lat;
    } sb_slot_t;

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// Youngest-match finder: lowest-index valid slot in [LO, HI] whose dst equals reg_i.
module sb_match
    import hazard_pkg::*;
#(
    parameter int NSTG = 3,
    parameter int REGW = 5,
    parameter int FSW  = $clog2(NSTG),
    parameter int LO   = 0,
    parameter int HI   = NSTG - 1
) (
    input  logic [REGW-1:0]          reg_i,
    input  sb_slot_t [NSTG-1:0]      slots_i,
    output logic                     hit_o,
    output logic [FSW-1:0]           idx_o,
    output logic [SB_LATW-1:0]       lat_o
);

    // Scan oldest to youngest so the youngest hit overwrites older ones.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        lat_o = '0;
        for (int k = HI; k >= LO; k--) begin
            if (slots_i[k].valid && (slots_i[k].dst == SB_REGW'(reg_i))) begin
                hit_o = 1'b1;
                idx_o = FSW'(k);
                lat_o = slots_i[k].lat;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for an in-order pipeline with NSTG post-decode stages: decode stalls,
// E-stage forward selects, E bubbles and a saturating stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSTG = 3,
    parameter int REGW = 5,
    parameter int CNTW = 16,
    parameter int FSW  = $clog2(NSTG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [REGW-1:0] rsD,
    input  logic [REGW-1:0] rtD,
    input  logic            use_rsD,
    input  logic            use_rtD,
    input  logic            wrD,
    input  logic [REGW-1:0] dstD,
    input  logic [FSW-1:0]  latD,
    input  logic            flush,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_e,
    output logic [FSW-1:0]  fwd_a,
    output logic [FSW-1:0]  fwd_b,
    output logic [CNTW-1:0] stall_cnt
);

    sb_slot_t [NSTG-1:0] slot_q, slot_d;
    logic [REGW-1:0]     rse_q, rse_d, rte_q, rte_d;
    logic                use_rse_q, use_rse_d, use_rte_q, use_rte_d;
    logic [CNTW-1:0]     stall_cnt_q, stall_cnt_d;

    logic               hit_rsd, hit_rtd, hit_rse, hit_rte;
    logic [FSW-1:0]     idx_rsd, idx_rtd, idx_rse, idx_rte;
    logic [SB_LATW-1:0] lat_rsd, lat_rtd, lat_rse, lat_rte;
    logic               stall, load;

    sb_match #(.NSTG(NSTG), .REGW(REGW), .FSW(FSW), .LO(0), .HI(NSTG-2)) u_rsd (
        .reg_i(rsD), .slots_i(slot_q), .hit_o(hit_rsd), .idx_o(idx_rsd), .lat_o(lat_rsd));
    sb_match #(.NSTG(NSTG), .REGW(REGW), .FSW(FSW), .LO(0), .HI(NSTG-2)) u_rtd (
        .reg_i(rtD), .slots_i(slot_q), .hit_o(hit_rtd), .idx_o(idx_rtd), .lat_o(lat_rtd));
    sb_match #(.NSTG(NSTG), .REGW(REGW), .FSW(FSW), .LO(1), .HI(NSTG-1)) u_rse (
        .reg_i(rse_q), .slots_i(slot_q), .hit_o(hit_rse), .idx_o(idx_rse), .lat_o(lat_rse));
    sb_match #(.NSTG(NSTG), .REGW(REGW), .FSW(FSW), .LO(1), .HI(NSTG-1)) u_rte (
        .reg_i(rte_q), .slots_i(slot_q), .hit_o(hit_rte), .idx_o(idx_rte), .lat_o(lat_rte));

    // A producer at slot k reaches slot k+1 when the consumer enters E; lat 0 means 1.
    function automatic logic not_ready(input logic [SB_LATW-1:0] lat, input logic [FSW-1:0] idx);
        int eff;
        eff = (lat == '0) ? 1 : int'(lat);
        return eff > (int'(idx) + 1);
    endfunction

    function automatic logic ready_in_e(input logic [SB_LATW-1:0] lat, input logic [FSW-1:0] idx);
        return int'(lat) <= int'(idx);
    endfunction

    assign stall = ~reset & issue_valid & ~flush &
                   ((use_rsD & hit_rsd & not_ready(lat_rsd, idx_rsd)) |
                    (use_rtD & hit_rtd & not_ready(lat_rtd, idx_rtd)));

    assign stall_f   = stall;
    assign stall_d   = stall;
    assign flush_e   = ~reset & (stall | flush);
    assign stall_cnt = stall_cnt_q;

    // The stall rule keeps lat <= k here; the readiness term only guards unreachable states.
    assign fwd_a = (use_rse_q && hit_rse && ready_in_e(lat_rse, idx_rse)) ? idx_rse : FSW'(FWD_RF);
    assign fwd_b = (use_rte_q && hit_rte && ready_in_e(lat_rte, idx_rte)) ? idx_rte : FSW'(FWD_RF);

    assign load = issue_valid & ~stall & ~flush;

    always_comb begin
        slot_d = '0;
        if (load) begin
            slot_d[0].valid = wrD && (dstD != '0);
            slot_d[0].dst   = SB_REGW'(dstD);
            slot_d[0].lat   = SB_LATW'(latD);
        end
        slot_d[1] = flush ? '0 : slot_q[0];
        for (int k = 2; k < NSTG; k++) begin
            slot_d[k] = slot_q[k-1];
        end
        rse_d       = load ? rsD : '0;
        rte_d       = load ? rtD : '0;
        use_rse_d   = load & use_rsD;
        use_rte_d   = load & use_rtD;
        stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q      <= '0;
            rse_q       <= '0;
            rte_q       <= '0;
            use_rse_q   <= 1'b0;
            use_rte_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            slot_q      <= slot_d;
            rse_q       <= rse_d;
            rte_q       <= rte_d;
            use_rse_q   <= use_rse_d;
            use_rte_q   <= use_rte_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a 3-stage instance and a 5-stage instance
// with a 4-bit stall counter for the long-latency and saturation cases.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       iv3, urs3, urt3, wr3, fl3;
    logic [4:0] rs3, rt3, dst3;
    logic [1:0] lat3;
    logic       sf3, sd3, fe3;
    logic [1:0] fa3, fb3;
    logic [15:0] cnt3;

    logic       iv5, urs5, urt5, wr5, fl5;
    logic [4:0] rs5, rt5, dst5;
    logic [2:0] lat5;
    logic       sf5, sd5, fe5;
    logic [2:0] fa5, fb5;
    logic [3:0] cnt5;

    hazard_scoreboard #(.NSTG(3), .REGW(5), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .issue_valid(iv3), .rsD(rs3), .rtD(rt3),
        .use_rsD(urs3), .use_rtD(urt3), .wrD(wr3), .dstD(dst3), .latD(lat3),
        .flush(fl3), .stall_f(sf3), .stall_d(sd3), .flush_e(fe3),
        .fwd_a(fa3), .fwd_b(fb3), .stall_cnt(cnt3));

    hazard_scoreboard #(.NSTG(5), .REGW(5), .CNTW(4)) dut5 (
        .clk(clk), .reset(reset), .issue_valid(iv5), .rsD(rs5), .rtD(rt5),
        .use_rsD(urs5), .use_rtD(urt5), .wrD(wr5), .dstD(dst5), .latD(lat5),
        .flush(fl5), .stall_f(sf5), .stall_d(sd5), .flush_e(fe5),
        .fwd_a(fa5), .fwd_b(fb5), .stall_cnt(cnt5));

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic d3(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic wr,
                      input logic [4:0] dst, input logic [1:0] lat);
        iv3 = v; rs3 = rs; rt3 = rt; urs3 = urs; urt3 = urt; wr3 = wr; dst3 = dst; lat3 = lat;
    endtask

    task automatic d5(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic wr,
                      input logic [4:0] dst, input logic [2:0] lat);
        iv5 = v; rs5 = rs; rt5 = rt; urs5 = urs; urt5 = urt; wr5 = wr; dst5 = dst; lat5 = lat;
    endtask

    task automatic chk3(input string tag, input logic sd, input logic fe,
                        input logic [1:0] fa, input logic [1:0] fb);
        check({tag, ".stall_f"}, sf3, sd);
        check({tag, ".stall_d"}, sd3, sd);
        check({tag, ".flush_e"}, fe3, fe);
        check({tag, ".fwd_a"}, fa3, fa);
        check({tag, ".fwd_b"}, fb3, fb);
    endtask

    task automatic drain3();
        d3(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    // One lat-4 producer of $8 followed by a consumer of $8 on the 5-stage instance.
    task automatic pair5(input string tag);
        d5(1, 0, 0, 0, 0, 1, 8, 4);
        neg(); check({tag, ".prod_stall"}, sd5, 0);
        tick();
        d5(1, 8, 0, 1, 0, 1, 9, 1);
        for (int i = 0; i < 3; i++) begin
            neg(); check({tag, ".stall"}, sd5, 1); check({tag, ".flush_e"}, fe5, 1);
            tick();
        end
        neg(); check({tag, ".release"}, sd5, 0);
        tick();
        d5(0, 0, 0, 0, 0, 0, 0, 0);
        neg(); check({tag, ".fwd_a"}, fa5, 4); check({tag, ".fwd_b"}, fb5, 0);
        tick();
    endtask

    // A forwarded E operand must already be available at its source stage.
    always @(negedge clk) begin
        if (!reset && dut.use_rse_q && dut.hit_rse)
            check("e_lat_le_k", 32'(int'(dut.lat_rse) <= int'(dut.idx_rse)), 1);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; fl3 = 1'b0; fl5 = 1'b0;
        d3(0, 0, 0, 0, 0, 0, 0, 0);
        d5(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        neg();
        chk3("reset", 0, 0, 0, 0);
        check("reset.cnt3", cnt3, 0);
        check("reset.cnt5", cnt5, 0);
        check("reset.fwd5", fa5, 0);
        tick();
        reset = 1'b0;

        // lw $8 then add $9,$8,$10
        d3(1, 1, 0, 1, 0, 1, 8, 2);
        neg(); chk3("s1_lw", 0, 0, 0, 0); tick();
        d3(1, 8, 10, 1, 1, 1, 9, 1);
        neg(); chk3("s1_stall", 1, 1, 0, 0); check("s1_cnt0", cnt3, 0); tick();
        neg(); chk3("s1_release", 0, 0, 0, 0); check("s1_cnt1", cnt3, 1); tick();
        d3(0, 0, 0, 0, 0, 0, 0, 0);
        neg(); chk3("s1_fwd", 0, 0, 2, 0); check("s1_cnt_e", cnt3, 1); tick();
        drain3();

        // add $8; sub $11,$10,$8; or $12,$8,$0
        d3(1, 0, 0, 0, 0, 1, 8, 1);
        neg(); chk3("s2_add", 0, 0, 0, 0); tick();
        d3(1, 10, 8, 1, 1, 1, 11, 1);
        neg(); chk3("s2_sub", 0, 0, 0, 0); tick();
        d3(1, 8, 0, 1, 1, 1, 12, 1);
        neg(); chk3("s2_sub_in_e", 0, 0, 0, 1); tick();
        d3(0, 0, 0, 0, 0, 0, 0, 0);
        neg(); chk3("s2_or_in_e", 0, 0, 2, 0); tick();
        drain3();

        // add $8; addi $8; consumer of $8 on both operands
        d3(1, 0, 0, 0, 0, 1, 8, 1);
        neg(); chk3("s3_add", 0, 0, 0, 0); tick();
        d3(1, 1, 0, 1, 0, 1, 8, 1);
        neg(); chk3("s3_addi", 0, 0, 0, 0); tick();
        d3(1, 8, 8, 1, 1, 1, 13, 1);
        neg(); chk3("s3_cons", 0, 0, 0, 0); tick();
        d3(0, 0, 0, 0, 0, 0, 0, 0);
        neg(); chk3("s3_fwd", 0, 0, 1, 1); tick();
        drain3();

        // lw $0 then consumer of $0
        d3(1, 1, 0, 1, 0, 1, 0, 2);
        neg(); chk3("s4_lw0", 0, 0, 0, 0); tick();
        d3(1, 0, 0, 1, 1, 1, 14, 1);
        neg(); chk3("s4_cons", 0, 0, 0, 0); tick();
        d3(0, 0, 0, 0, 0, 0, 0, 0);
        neg(); chk3("s4_fwd", 0, 0, 0, 0); check("s4_cnt", cnt3, 1); tick();
        drain3();

        // flush in the load-use stall cycle
        d3(1, 1, 0, 1, 0, 1, 8, 2);
        neg(); chk3("s5_lw", 0, 0, 0, 0); tick();
        d3(1, 8, 10, 1, 1, 1, 9, 1);
        fl3 = 1'b1;
        neg(); chk3("s5_flush", 0, 1, 0, 0); tick();
        fl3 = 1'b0;
        d3(1, 8, 0, 1, 0, 1, 15, 1);
        neg();
        check("s5_slot0_valid", dut.slot_q[0].valid, 0);
        check("s5_slot1_valid", dut.slot_q[1].valid, 0);
        chk3("s5_after_flush", 0, 0, 0, 0);
        check("s5_cnt", cnt3, 1);
        tick();
        drain3();

        // reset in the middle of a stall
        d3(1, 1, 0, 1, 0, 1, 8, 2);
        neg(); tick();
        d3(1, 8, 10, 1, 1, 1, 9, 1);
        neg(); chk3("s5_pre_reset", 1, 1, 0, 0);
        #1 reset = 1'b1;
        tick();
        reset = 1'b0;
        d3(0, 0, 0, 0, 0, 0, 0, 0);
        neg(); chk3("s5_post_reset", 0, 0, 0, 0); check("s5_post_reset.cnt", cnt3, 0); tick();

        // 5-stage pipeline: lat-4 producer, three stalls, then saturation of a 4-bit counter
        pair5("s6_p1");
        neg(); check("s6_cnt_after1", cnt5, 3); tick();
        pair5("s6_p2");
        pair5("s6_p3");
        pair5("s6_p4");
        neg(); check("s6_cnt_after4", cnt5, 12); tick();
        pair5("s6_p5");
        neg(); check("s6_cnt_after5", cnt5, 15); tick();
        pair5("s6_p6");
        neg(); check("s6_cnt_sat", cnt5, 15); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
